// File: rtl/piso_stream_buffer.sv
// Parallel-in/serial-out block buffer with valid/ready on both sides, per-block
// word counts, last tagging and flush. Define PISO_CHAIN_EN for bubble-free block chaining.
module piso_stream_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 17,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEPTH*WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0]       in_count,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [CNT_W-1:0]       words_left
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] load_word [DEPTH];
  logic [WIDTH-1:0] shift_word [DEPTH];
  logic [CNT_W-1:0] words_left_reg;
  logic [CNT_W-1:0] count_clamped;
  logic             last_reg;
  logic             load;
  logic             advance;

  assign count_clamped = (in_count == '0 || in_count > DEPTH_CNT) ? DEPTH_CNT : in_count;

  // Words past the count are loaded as zero, so a drained buffer reads back all zeros.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      assign load_word[gi] = (CNT_W'(gi) < count_clamped)
                             ? in_data[(DEPTH-gi)*WIDTH-1 -: WIDTH] : '0;
      if (gi == DEPTH - 1) begin : g_tail
        assign shift_word[gi] = '0;
      end else begin : g_body
        assign shift_word[gi] = mem_reg[gi+1];
      end
    end
  endgenerate

`ifdef PISO_CHAIN_EN
  // The final word leaving this cycle frees the buffer for a new block on the same edge.
  assign in_ready = !flush && ((state_reg == EMPTY) ||
                               (state_reg == SHIFT && words_left_reg == ONE_CNT && out_ready));
`else
  assign in_ready = !flush && (state_reg == EMPTY);
`endif

  assign load    = in_valid && in_ready;
  assign advance = (state_reg == SHIFT) && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_reg      <= EMPTY;
      words_left_reg <= '0;
      last_reg       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (load) begin
      state_reg      <= SHIFT;
      words_left_reg <= count_clamped;
      last_reg       <= in_last;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= load_word[i];
    end else if (advance) begin
      words_left_reg <= words_left_reg - ONE_CNT;
      if (words_left_reg == ONE_CNT) state_reg <= EMPTY;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= shift_word[i];
    end
  end

  assign out_valid  = (state_reg == SHIFT);
  assign out_data   = mem_reg[0];
  assign out_last   = last_reg && (words_left_reg == ONE_CNT);
  assign words_left = words_left_reg;

endmodule

// File: tb/tb_piso_stream_buffer.sv
// Self-checking bench for piso_stream_buffer (WIDTH=8, DEPTH=4): queue-based
// reference model checked every cycle, a table of blocks, and directed corner sequences.
module tb_piso_stream_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef PISO_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [DEPTH*WIDTH-1:0] in_data = '0;
  logic [CNT_W-1:0]       in_count = '0;
  logic                   in_last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic [CNT_W-1:0]       words_left;

  piso_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_count(in_count), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .words_left(words_left)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  bit m_loaded;

  // Reference model: the words still owed to the consumer, oldest first.
  logic [WIDTH-1:0] mq[$];
  logic             m_last = 1'b0;

  logic [WIDTH-1:0] cap_w[$];
  logic             cap_l[$];
  int               cap_c[$];

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        last;
    int          exp_n;
    logic [31:0] exp_words;
    logic        exp_last;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    logic exp_ready;
    int   n;
    logic [31:0] d;
    @(negedge clk);
    exp_ready = !flush && (mq.size() == 0 || (CHAIN && mq.size() == 1 && out_ready));
    if (chk_en) begin
      chk("out_valid",  32'(out_valid),  32'(mq.size() > 0));
      chk("out_data",   32'(out_data),   (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      chk("out_last",   32'(out_last),   32'(m_last && mq.size() == 1));
      chk("words_left", 32'(words_left), 32'(mq.size()));
      chk("in_ready",   32'(in_ready),   32'(exp_ready));
    end
    if (out_valid === 1'b1 && out_ready) begin
      cap_w.push_back(out_data);
      cap_l.push_back(out_last);
      cap_c.push_back(cyc);
      $display("[TB] cyc %0d out word=%h last=%0d left=%0d", cyc, out_data, out_last, words_left);
    end
    m_loaded = 1'b0;
    if (rst || flush) begin
      mq.delete();
      m_last = 1'b0;
    end else if (in_valid && exp_ready) begin
      mq.delete();
      n = (in_count == 0 || in_count > DEPTH) ? DEPTH : int'(in_count);
      d = in_data;
      for (int i = 0; i < n; i++) mq.push_back(d[31-8*i -: 8]);
      m_last = in_last;
      m_loaded = 1'b1;
      $display("[TB] cyc %0d load data=%h count=%0d last=%0d", cyc, in_data, in_count, in_last);
    end else if (mq.size() > 0 && out_ready) begin
      void'(mq.pop_front());
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_w.delete();
    cap_l.delete();
    cap_c.delete();
  endtask

  task automatic load_block(input logic [31:0] d, input logic [2:0] c, input logic l);
    in_data = d; in_count = c; in_last = l; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'hA1B2C3D4, 3'd4, 1'b1, 4, 32'hA1B2C3D4, 1'b1};
    vecs[1] = '{32'h11223344, 3'd2, 1'b0, 2, 32'h11220000, 1'b0};
    vecs[2] = '{32'h55667788, 3'd0, 1'b1, 4, 32'h55667788, 1'b1};
    vecs[3] = '{32'h99AABBCC, 3'd7, 1'b0, 4, 32'h99AABBCC, 1'b0};
    vecs[4] = '{32'hDEADBEEF, 3'd1, 1'b1, 1, 32'hDE000000, 1'b1};
    vecs[5] = '{32'h0F1E2D3C, 3'd3, 1'b0, 3, 32'h0F1E2D00, 1'b0};

    // Initial reset, then start checking against the model.
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset held two cycles in the middle of a block.
    out_ready = 1'b1;
    load_block(32'hA1B2C3D4, 3'd4, 1'b1);
    cycle();
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_data",   32'(out_data),   32'd0);
    chk("rst_words_left", 32'(words_left), 32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    rst = 1'b0;
    cycle();

    // Table of blocks drained at full rate.
    for (int v = 0; v < 6; v++) begin
      logic [31:0] ew;
      clear_cap();
      out_ready = 1'b1;
      load_block(vecs[v].data, vecs[v].cnt, vecs[v].last);
      for (int k = 0; k < 6; k++) cycle();
      ew = vecs[v].exp_words;
      chk($sformatf("vec%0d_count", v), 32'(cap_w.size()), 32'(vecs[v].exp_n));
      for (int i = 0; i < vecs[v].exp_n && i < cap_w.size(); i++) begin
        chk($sformatf("vec%0d_word%0d", v, i), 32'(cap_w[i]), 32'(ew[31-8*i -: 8]));
        chk($sformatf("vec%0d_last%0d", v, i), 32'(cap_l[i]),
            32'((i == vecs[v].exp_n - 1) && vecs[v].exp_last));
      end
      if (cap_c.size() == vecs[v].exp_n && vecs[v].exp_n > 1)
        chk($sformatf("vec%0d_span", v), 32'(cap_c[vecs[v].exp_n-1] - cap_c[0]),
            32'(vecs[v].exp_n - 1));
    end

    // Stalls: out_ready pattern 1,0,0,1,0,1,1,0,1,1,1,1.
    begin
      logic [11:0] pat = 12'b1001_0110_1111;
      logic [31:0] exp_w = 32'hA1B2C3D4;
      clear_cap();
      load_block(32'hA1B2C3D4, 3'd4, 1'b1);
      for (int k = 0; k < 12; k++) begin
        out_ready = pat[11-k];
        cycle();
      end
      chk("stall_count", 32'(cap_w.size()), 32'd4);
      for (int i = 0; i < 4 && i < cap_w.size(); i++)
        chk($sformatf("stall_word%0d", i), 32'(cap_w[i]), 32'(exp_w[31-8*i -: 8]));
    end

    // Flush with three words still pending.
    out_ready = 1'b0;
    load_block(32'hC1C2C3C4, 3'd4, 1'b1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("flush_pre_left", 32'(words_left), 32'd3);
    flush = 1'b1;
    #1 chk("flush_in_ready_low", 32'(in_ready), 32'd0);
    cycle();
    flush = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    clear_cap();
    out_ready = 1'b1;
    load_block(32'h5A6B7C8D, 3'd4, 1'b0);
    for (int k = 0; k < 6; k++) cycle();
    chk("flush_next_count", 32'(cap_w.size()), 32'd4);
    if (cap_w.size() > 0) chk("flush_next_word0", 32'(cap_w[0]), 32'h5A);

    // Two blocks offered back to back.
    begin
      logic [31:0] blk[2];
      int idx = 0;
      int guard = 0;
      blk[0] = 32'h01020304;
      blk[1] = 32'h05060708;
      clear_cap();
      out_ready = 1'b1;
      in_count = 3'd4;
      in_last = 1'b0;
      in_data = blk[0];
      in_valid = 1'b1;
      while (idx < 2 && guard < 20) begin
        cycle();
        guard++;
        if (m_loaded) begin
          idx++;
          if (idx < 2) begin
            in_data = blk[idx];
            in_last = 1'b1;
          end else in_valid = 1'b0;
        end
      end
      chk("b2b_accept_timeout", 32'(idx), 32'd2);
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) cycle();
      chk("b2b_count", 32'(cap_w.size()), 32'd8);
      for (int i = 0; i < 8 && i < cap_w.size(); i++)
        chk($sformatf("b2b_word%0d", i), 32'(cap_w[i]), 32'(i + 1));
      if (cap_c.size() == 8)
        chk("b2b_span", 32'(cap_c[7] - cap_c[0]), CHAIN ? 32'd7 : 32'd8);
    end

    // Randomized traffic against the model.
    clear_cap();
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = $urandom;
      in_count  = 3'($urandom_range(0, 7));
      in_last   = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
